// File: rtl/code_6b5b_pkg.sv
// Shared 5b/6b code tables and running-disparity constants.
// Both the encoder and the decoder index these tables by the 5-bit data value.
package code_6b5b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam int NUM_CODES = 32;

    // Column used when the running disparity is negative; bit 5 is the first transmitted bit.
    localparam logic [0:NUM_CODES-1][5:0] CODE_RD_NEG = {
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    localparam logic [0:NUM_CODES-1][5:0] CODE_RD_POS = {
        6'b011000, 6'b100010, 6'b010010, 6'b110001,
        6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001,
        6'b001110, 6'b010001, 6'b100001, 6'b010100
    };

    function automatic logic [2:0] sym_weight(input logic [5:0] sym);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 6; i++) begin
            w = w + {2'b00, sym[i]};
        end
        return w;
    endfunction

endpackage

// File: rtl/dec_6b5b_sym6_classify.sv
// Combinational 6b symbol classifier: decodes against both disparity columns
// and derives the error flags and the next running disparity.
module sym6_classify
    import code_6b5b_pkg::*;
(
    input  logic [5:0] in_sym,
    input  logic       rd,
    output logic [4:0] data,
    output logic       code_err,
    output logic       disp_err,
    output logic       next_rd
);

    logic [NUM_CODES-1:0] hit_neg;
    logic [NUM_CODES-1:0] hit_pos;
    logic [2:0]           weight;

    generate
        for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_match
            assign hit_neg[gi] = (in_sym == CODE_RD_NEG[gi]);
            assign hit_pos[gi] = (in_sym == CODE_RD_POS[gi]);
        end
    endgenerate

    assign weight = sym_weight(in_sym);

    // A symbol found in the "wrong" column still decodes; disparity resyncs to its weight.
    always_comb begin
        data     = 5'd0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (hit_neg[i] || hit_pos[i]) begin
                data = 5'(i);
            end
        end
        code_err = !((|hit_neg) || (|hit_pos));
        disp_err = !code_err &&
                   !(((rd == RD_NEG) && (|hit_neg)) || ((rd == RD_POS) && (|hit_pos)));
        next_rd  = rd;
        if (!code_err) begin
            if (weight == 3'd4) begin
                next_rd = RD_POS;
            end else if (weight == 3'd2) begin
                next_rd = RD_NEG;
            end
        end
    end

endmodule

// File: rtl/dec_6b5b.sv
// 6b/5b decoder with valid/ready handshake, running-disparity tracking and a
// saturating error counter. One cycle of latency, full throughput.
module dec_6b5b
    import code_6b5b_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           in_sym,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_data,
    output logic                 out_code_err,
    output logic                 out_disp_err,
    output logic                 rd,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic                 out_valid_reg;
    logic [4:0]           out_data_reg;
    logic                 code_err_reg;
    logic                 disp_err_reg;
    logic                 rd_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic [4:0] cls_data;
    logic       cls_code_err;
    logic       cls_disp_err;
    logic       cls_next_rd;
    logic       accept;

    sym6_classify u_classify (
        .in_sym   (in_sym),
        .rd       (rd_reg),
        .data     (cls_data),
        .code_err (cls_code_err),
        .disp_err (cls_disp_err),
        .next_rd  (cls_next_rd)
    );

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 5'd0;
            code_err_reg  <= 1'b0;
            disp_err_reg  <= 1'b0;
            rd_reg        <= RD_NEG;
            err_cnt_reg   <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= cls_data;
                code_err_reg  <= cls_code_err;
                disp_err_reg  <= cls_disp_err;
                rd_reg        <= cls_next_rd;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // Clear wins over a same-cycle increment.
            if (err_clr) begin
                err_cnt_reg <= '0;
            end else if (accept && (cls_code_err || cls_disp_err) && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_code_err = code_err_reg;
    assign out_disp_err = disp_err_reg;
    assign rd           = rd_reg;
    assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_dec_6b5b.sv
// Bench for dec_6b5b: directed vector table, handshake/reset/saturation sequences,
// then randomized traffic against a rule-based reference model.
module tb_dec_6b5b;

    localparam int W = 4;
    localparam int CNT_MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   in_sym = 6'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [4:0]   out_data;
    logic         out_code_err;
    logic         out_disp_err;
    logic         rd;
    logic [W-1:0] err_cnt;
    logic         err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    dec_6b5b #(.ERR_CNT_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sym       (in_sym),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_code_err (out_code_err),
        .out_disp_err (out_disp_err),
        .rd           (rd),
        .err_cnt      (err_cnt),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Only the RD- column; RD+ is its complement for unbalanced codes and for D.07.
    logic [5:0] ref_neg [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    function automatic void ref_decode(input logic [5:0] s, input logic r,
                                       output logic [4:0] d, output logic ce,
                                       output logic de, output logic nr);
        int w;
        w = $countones(s);
        d = 5'd0; ce = 1'b0; de = 1'b0; nr = r;
        if (w < 2 || w > 4 || s == 6'b000011 || s == 6'b110000 ||
            s == 6'b001111 || s == 6'b111100) begin
            ce = 1'b1;
            return;
        end
        for (int i = 0; i < 32; i++) begin
            if (s == ref_neg[i]) d = 5'(i);
            if (($countones(ref_neg[i]) != 3 || i == 7) && s == ~ref_neg[i]) d = 5'(i);
        end
        if (w == 3) begin
            if (s == 6'b000111 && r == 1'b0) de = 1'b1;
            if (s == 6'b111000 && r == 1'b1) de = 1'b1;
        end else if (w == 2) begin
            de = (r == 1'b0);
            nr = 1'b0;
        end else begin
            de = (r == 1'b1);
            nr = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0] sym;
        logic [4:0] data;
        logic       ce;
        logic       de;
        logic       rd;
        int         cnt;
    } vec_t;

    vec_t vecs[14];

    logic       m_valid, m_ce, m_de, m_rd, m_acc, m_ready;
    logic [4:0] m_data;
    int         m_cnt;
    logic [4:0] r_d;
    logic       r_ce, r_de, r_nr;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{6'b100111, 5'd0,  1'b0, 1'b0, 1'b1, 0};
        vecs[1]  = '{6'b011000, 5'd0,  1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{6'b011000, 5'd0,  1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{6'b110000, 5'd0,  1'b1, 1'b0, 1'b0, 2};
        vecs[4]  = '{6'b111111, 5'd0,  1'b1, 1'b0, 1'b0, 3};
        vecs[5]  = '{6'b100111, 5'd0,  1'b0, 1'b0, 1'b1, 3};
        vecs[6]  = '{6'b000111, 5'd7,  1'b0, 1'b0, 1'b1, 3};
        vecs[7]  = '{6'b111000, 5'd7,  1'b0, 1'b1, 1'b1, 4};
        vecs[8]  = '{6'b011101, 5'd1,  1'b0, 1'b1, 1'b1, 5};
        vecs[9]  = '{6'b100010, 5'd1,  1'b0, 1'b0, 1'b0, 5};
        vecs[10] = '{6'b101001, 5'd5,  1'b0, 1'b0, 1'b0, 5};
        vecs[11] = '{6'b111000, 5'd7,  1'b0, 1'b0, 1'b0, 5};
        vecs[12] = '{6'b001111, 5'd0,  1'b1, 1'b0, 1'b0, 6};
        vecs[13] = '{6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 7};

        step();
        step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_code_err", out_code_err, 0);
        chk("reset_disp_err", out_disp_err, 0);
        chk("reset_rd", rd, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // Directed vectors, back to back with out_ready high.
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_sym   = vecs[i].sym;
            step();
            $display("vec %0d sym=%b data=%0d ce=%0d de=%0d rd=%0d cnt=%0d",
                     i, vecs[i].sym, out_data, out_code_err, out_disp_err, rd, err_cnt);
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, vecs[i].data);
            chk("vec_code_err", out_code_err, vecs[i].ce);
            chk("vec_disp_err", out_disp_err, vecs[i].de);
            chk("vec_rd", rd, vecs[i].rd);
            chk("vec_err_cnt", err_cnt, vecs[i].cnt);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);

        // Reset while a result is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sym    = 6'b100111;
        step();
        in_valid = 1'b0;
        chk("held_valid", out_valid, 1);
        chk("held_rd", rd, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_rd", rd, 0);
        chk("midrst_cnt", err_cnt, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sym    = 6'b011000;
        step();
        in_valid = 1'b0;
        $display("post-reset sym=011000 de=%0d rd=%0d cnt=%0d", out_disp_err, rd, err_cnt);
        chk("postrst_disp_err", out_disp_err, 1);
        chk("postrst_rd", rd, 0);
        chk("postrst_cnt", err_cnt, 1);
        step();

        // Backpressure: three offers with out_ready low, then streaming.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sym    = 6'b101001;
        step();
        in_sym = 6'b110001;
        for (int i = 0; i < 3; i++) begin
            $display("stall %0d data=%0d in_ready=%0d", i, out_data, in_ready);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 5);
            chk("stall_in_ready", in_ready, 0);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        step();
        chk("stream_b", out_data, 3);
        in_sym = 6'b100101;
        step();
        chk("stream_c", out_data, 9);
        in_sym = 6'b010101;
        step();
        chk("stream_d", out_data, 10);
        chk("stream_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", out_valid, 0);

        // Saturation and clear priority.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_cnt", err_cnt, 0);
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            in_valid = 1'b1;
            in_sym   = 6'b000000;
            step();
            $display("sat %0d err_cnt=%0d", i, err_cnt);
            chk("sat_cnt", err_cnt, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
        end
        err_clr = 1'b1;
        step();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        $display("clr+err err_cnt=%0d", err_cnt);
        chk("clr_priority", err_cnt, 0);
        step();

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_valid = 1'b0; m_data = 5'd0; m_ce = 1'b0; m_de = 1'b0; m_rd = 1'b0; m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sym    = 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
            #1;
            m_ready = !m_valid || out_ready;
            chk("rnd_in_ready", in_ready, m_ready);
            m_acc = in_valid && m_ready;
            ref_decode(in_sym, m_rd, r_d, r_ce, r_de, r_nr);
            if (err_clr) m_cnt = 0;
            else if (m_acc && (r_ce || r_de) && m_cnt < CNT_MAX) m_cnt++;
            if (m_acc) begin
                m_valid = 1'b1; m_data = r_d; m_ce = r_ce; m_de = r_de; m_rd = r_nr;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            step();
            if (m_acc)
                $display("rnd %0d sym=%b data=%0d ce=%0d de=%0d rd=%0d cnt=%0d",
                         n, in_sym, out_data, out_code_err, out_disp_err, rd, err_cnt);
            chk("rnd_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_data", out_data, m_data);
                chk("rnd_code_err", out_code_err, m_ce);
                chk("rnd_disp_err", out_disp_err, m_de);
            end
            chk("rnd_rd", rd, m_rd);
            chk("rnd_err_cnt", err_cnt, m_cnt);
        end
        in_valid = 1'b0;
        err_clr  = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_6b5b.md
DEC_6B5B -- requirements
Module: dec_6b5b

Interface
REQ-001 Parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream offers a 6-bit symbol this cycle.
REQ-005 in_ready  output  1  block accepts the symbol this cycle.
REQ-006 in_sym  input  6  received 6b code group, bit 5 = first bit in the code table.
REQ-007 out_valid  output  1  decoded result held in the output register.
REQ-008 out_ready  input  1  downstream consumes the result this cycle.
REQ-009 out_data  output  5  decoded 5-bit data.
REQ-010 out_code_err  output  1  symbol absent from both disparity columns.
REQ-011 out_disp_err  output  1  symbol legal in code space but wrong for the current running disparity.
REQ-012 rd  output  1  current running disparity: 0 = negative, 1 = positive.
REQ-013 err_cnt  output  ERR_CNT_W  count of accepted symbols flagged code_err or disp_err.
REQ-014 err_clr  input  1  clears err_cnt.

Function
REQ-015 Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready, combinational; simultaneous drain and accept in one cycle sustains full throughput.
REQ-017 Latency one cycle: a symbol accepted at edge N appears on out_* after edge N, held stable until consumed.
REQ-018 Decode is the exact inverse of the team 5b/6b table, both columns.
REQ-019 Symbol weight (popcount) classifies it: weight 3 neutral, weight 2 negative, weight 4 positive, weights 0/1/5/6 illegal.
REQ-020 Weight 3, except 000111/111000: decode; rd unchanged; no error.
REQ-021 000111 legal only when rd=1, 111000 legal only when rd=0; both decode to 00111; rd unchanged; wrong rd gives out_disp_err=1.
REQ-022 Weight 2 in the table: legal only when rd=1; decode; rd becomes 0. If rd was 0: out_disp_err=1, data still decoded, rd forced to 0 (resync).
REQ-023 Weight 4 in the table: legal only when rd=0; decode; rd becomes 1. If rd was 1: out_disp_err=1, data still decoded, rd forced to 1 (resync).
REQ-024 Weights 0/1/5/6 and 000011, 110000, 001111, 111100: out_code_err=1, out_disp_err=0, out_data=00000, rd unchanged.
REQ-025 rd updates only on an input transfer.
REQ-026 err_cnt increments by 1 per accepted errored symbol; saturates at all-ones.
REQ-027 err_clr has priority over a same-cycle increment; err_cnt = 0 next cycle.

Reset
REQ-028 On rst_n=0 at a clock edge: out_valid=0, out_data=0, out_code_err=0, out_disp_err=0, rd=0, err_cnt=0.
REQ-029 Reset mid-stream discards the held result. The first symbol after reset is judged against rd=0.

Structure
REQ-030 Package code_6b5b_pkg holds both 32-entry code tables (rd-positive and rd-negative columns) and the RD_NEG/RD_POS constants. Encoder and decoder share these.
REQ-031 One sub-module, sym6_classify: combinational, in_sym + rd -> data, code_err, disp_err, next_rd. dec_6b5b owns the handshake, rd and err_cnt registers.

Verification
REQ-032 After reset, send 100111 then 011000 -> out_data 00000, 00000; rd 1 then 0; no errors.
REQ-033 At rd=0, send 011000 -> out_data 00000, out_disp_err=1, rd stays 0, err_cnt=1.
REQ-034 Send 110000 then 111111 -> out_code_err=1 for both, out_data 00000, rd unchanged, err_cnt +2.
REQ-035 At rd=1, send 000111 -> out_data 00111, no error. Then send 111000 at rd=1 -> out_disp_err=1.
REQ-036 Hold out_ready=0 across 3 offered symbols -> in_ready=0 after the first, out_* stable. Then assert out_ready with in_valid=1 each cycle -> one symbol per cycle, no loss or duplication.
REQ-037 Force err_cnt to all-ones, send an errored symbol -> err_cnt unchanged. Assert err_clr on the same cycle as another error -> err_cnt=0.
